// File: rtl/bus_resp_pkg.sv
// Shared types and constants for the 65C02 bus responder.
// State encoding, data-register reset/timeout values and DI source selectors.
package bus_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] DI_TIMEOUT = 8'hFF;
    localparam logic [7:0] DATA_RST   = 8'h00;

    localparam logic SRC_RAM = 1'b0;
    localparam logic SRC_EXT = 1'b1;

endpackage

// File: rtl/bus_resp_ram.sv
// Single-port INT_WORDS x 8 RAM, one-cycle registered read, no reset.
// Read-during-write returns the old contents; no backpressure (always ready).
module bus_resp_ram #(
    parameter int WORDS = 512
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o
);

    logic [7:0] mem_q [WORDS];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_resp.sv
// 65C02 bus responder: zero-wait internal RAM below INT_WORDS, everything else bridged to ext req/ack.
// Internal reads land on DI one cycle later; external accesses hold RDY low until ack or TIMEOUT.
module bus_resp
    import bus_resp_pkg::*;
#(
    parameter int INT_WORDS = 512,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic [15:0] AB,
    input  logic        WE,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        bus_err
);

    localparam int AW = $clog2(INT_WORDS);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        src_q, src_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_q, err_d;

    logic        int_hit;
    logic        timeout_hit;
    logic        rdy_c;
    logic        ram_en;
    logic [7:0]  ram_rdata;

    assign int_hit     = ({1'b0, AB} < 17'(INT_WORDS));
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!int_hit) state_d = REQ;
            REQ:     if (ext_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // DONE completes unconditionally so the held external AB cannot re-trigger.
    always_comb begin
        rdy_c  = 1'b0;
        ram_en = 1'b0;
        case (state_q)
            IDLE: begin
                rdy_c  = int_hit;
                ram_en = int_hit;
            end
            DONE:    rdy_c = 1'b1;
            default: rdy_c = 1'b0;
        endcase
    end

    assign RDY = RST_N & rdy_c;

    always_comb begin
        cnt_d   = cnt_q;
        data_d  = data_q;
        src_d   = src_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        if (state_q == IDLE && !int_hit) begin
            addr_d  = AB;
            we_d    = WE;
            wdata_d = DO;
            req_d   = 1'b1;
            cnt_d   = 8'd0;
        end
        if (state_q == REQ) begin
            cnt_d = cnt_q + 8'd1;
            if (ext_ack) begin
                data_d = ext_rdata;
                req_d  = 1'b0;
            end else if (timeout_hit) begin
                data_d = DI_TIMEOUT;
                err_d  = 1'b1;
                req_d  = 1'b0;
            end
        end
        // DI source only moves on a completing edge so DI holds between accesses.
        if (rdy_c) begin
            src_d = (state_q == DONE) ? SRC_EXT : SRC_RAM;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q   <= 8'd0;
            data_q  <= DATA_RST;
            src_q   <= SRC_EXT;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            src_q   <= src_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    bus_resp_ram #(
        .WORDS (INT_WORDS)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en & RST_N),
        .we_i    (WE),
        .addr_i  (AB[AW-1:0]),
        .wdata_i (DO),
        .rdata_o (ram_rdata)
    );

    assign DI        = (src_q == SRC_EXT) ? data_q : ram_rdata;
    assign ext_req   = req_q;
    assign ext_we    = we_q;
    assign ext_addr  = addr_q;
    assign ext_wdata = wdata_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_bus_resp.sv
// Scoreboard bench for bus_resp: expected DI bytes queued at completing cycles, checked one cycle later.
module tb_bus_resp;

    logic        clk = 1'b0;
    logic        RST_N;
    logic [15:0] AB;
    logic        WE;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        RDY;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata;
    logic        bus_err;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model [0:511];

    always #5 clk = ~clk;

    bus_resp #(
        .INT_WORDS (512),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .RST_N     (RST_N),
        .AB        (AB),
        .WE        (WE),
        .DO        (DO),
        .DI        (DI),
        .RDY       (RDY),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .bus_err   (bus_err)
    );

    // Inputs change at the falling edge; outputs are observed 1ns before the rising edge.
    task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d, input logic ack);
        @(negedge clk);
        AB = a; WE = w; DO = d; ext_ack = ack;
        #4;
    endtask

    task automatic run_ext(input logic [15:0] a, input logic w, input logic [7:0] d,
                           input int ack_at, input logic [7:0] rd,
                           output int waits, output int reqs, output int errs,
                           output logic [15:0] addr_seen, output logic we_seen, output logic [7:0] wd_seen);
        waits = 0; reqs = 0; errs = 0;
        addr_seen = 16'h0; we_seen = 1'b0; wd_seen = 8'h0;
        drive(a, w, d, 1'b0);
        for (int i = 0; i < 300 && !RDY; i++) begin
            waits++;
            errs += int'(bus_err);
            @(negedge clk);
            ext_ack = 1'b0;
            if (ext_req) begin
                reqs++;
                if (reqs == 1) begin
                    addr_seen = ext_addr; we_seen = ext_we; wd_seen = ext_wdata;
                end
                if (reqs == ack_at) begin
                    ext_ack = 1'b1;
                    ext_rdata = rd;
                end
            end
            #4;
        end
        if (!RDY) waits = -1;
        errs += int'(bus_err);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; AB = 16'h0042; WE = 1'b0; DO = 8'h00; ext_ack = 1'b0; ext_rdata = 8'h00;
        repeat (2) @(negedge clk);
        #4;
        n_cmp++; if (RDY !== 1'b0) begin n_err++; $display("FAIL reset_rdy: RDY=%b expected 0", RDY); end
        n_cmp++; if (DI !== 8'h00) begin n_err++; $display("FAIL reset_di: DI=%h expected 00", DI); end
        n_cmp++; if (ext_req !== 1'b0 || bus_err !== 1'b0) begin
            n_err++; $display("FAIL reset_ctl: ext_req=%b bus_err=%b expected 0 0", ext_req, bus_err); end
        n_cmp++; if (ext_addr !== 16'h0 || ext_we !== 1'b0 || ext_wdata !== 8'h0) begin
            n_err++; $display("FAIL reset_ext: addr=%h we=%b wdata=%h expected 0000 0 00", ext_addr, ext_we, ext_wdata); end
        @(negedge clk);
        RST_N = 1'b1;
    endtask

    task automatic test_int_rw();
        logic [7:0] e;
        drive(16'h0042, 1'b1, 8'h5A, 1'b0);
        model[16'h042] = 8'h5A;
        n_cmp++; if (RDY !== 1'b1) begin n_err++; $display("FAIL int_write_rdy: RDY=%b expected 1", RDY); end
        drive(16'h0042, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (RDY !== 1'b1) begin n_err++; $display("FAIL int_read_rdy: RDY=%b expected 1", RDY); end
        exp_q.push_back(model[16'h042]);
        drive(16'h0100, 1'b1, 8'h11, 1'b0);
        model[16'h100] = 8'h11;
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL int_read_di: DI=%h expected %h", DI, e); end
    endtask

    task automatic test_ext_read();
        int w, r, er; logic [15:0] as; logic ws; logic [7:0] ds; logic [7:0] e;
        run_ext(16'h8000, 1'b0, 8'h00, 3, 8'hC3, w, r, er, as, ws, ds);
        n_cmp++; if (w !== 4) begin n_err++; $display("FAIL ext_read_waits: RDY low %0d cycles expected 4", w); end
        n_cmp++; if (as !== 16'h8000 || ws !== 1'b0) begin
            n_err++; $display("FAIL ext_read_addr: ext_addr=%h ext_we=%b expected 8000 0", as, ws); end
        n_cmp++; if (ext_req !== 1'b0 || er !== 0) begin
            n_err++; $display("FAIL ext_read_done: ext_req=%b bus_err_cycles=%0d expected 0 0", ext_req, er); end
        exp_q.push_back(8'hC3);
        drive(16'h0042, 1'b0, 8'h00, 1'b0);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL ext_read_di: DI=%h expected %h", DI, e); end
        n_cmp++; if (RDY !== 1'b1) begin n_err++; $display("FAIL ext_then_int_rdy: RDY=%b expected 1", RDY); end
        exp_q.push_back(model[16'h042]);
        drive(16'h01FF, 1'b1, 8'hE7, 1'b0);
        model[16'h1FF] = 8'hE7;
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL ext_then_int_di: DI=%h expected %h", DI, e); end
    endtask

    task automatic test_ext_write();
        int w, r, er; logic [15:0] as; logic ws; logic [7:0] ds;
        run_ext(16'hC123, 1'b1, 8'h99, 2, 8'h00, w, r, er, as, ws, ds);
        n_cmp++; if (w !== 3) begin n_err++; $display("FAIL ext_write_waits: RDY low %0d cycles expected 3", w); end
        n_cmp++; if (as !== 16'hC123 || ws !== 1'b1 || ds !== 8'h99) begin
            n_err++; $display("FAIL ext_write_latch: addr=%h we=%b wdata=%h expected C123 1 99", as, ws, ds); end
    endtask

    task automatic test_timeout();
        int w, r, er; logic [15:0] as; logic ws; logic [7:0] ds; logic [7:0] e;
        run_ext(16'hA000, 1'b0, 8'h00, 0, 8'h00, w, r, er, as, ws, ds);
        n_cmp++; if (r !== 16) begin n_err++; $display("FAIL timeout_req_len: ext_req high %0d cycles expected 16", r); end
        n_cmp++; if (w !== 17) begin n_err++; $display("FAIL timeout_waits: RDY low %0d cycles expected 17", w); end
        n_cmp++; if (er !== 1 || bus_err !== 1'b1) begin
            n_err++; $display("FAIL timeout_err: bus_err cycles=%0d in_done=%b expected 1 1", er, bus_err); end
        exp_q.push_back(8'hFF);
        drive(16'h0042, 1'b0, 8'h00, 1'b0);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL timeout_di: DI=%h expected %h", DI, e); end
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL timeout_err_pulse: bus_err=%b expected 0", bus_err); end
        exp_q.push_back(model[16'h042]);
        drive(16'h0100, 1'b0, 8'h00, 1'b0);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL timeout_next_di: DI=%h expected %h", DI, e); end
        exp_q.push_back(model[16'h100]);
        drive(16'h0100, 1'b1, 8'h11, 1'b0);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL timeout_next2_di: DI=%h expected %h", DI, e); end
    endtask

    task automatic test_ack_at_timeout();
        int w, r, er; logic [15:0] as; logic ws; logic [7:0] ds; logic [7:0] e;
        run_ext(16'hB000, 1'b0, 8'h00, 16, 8'hA5, w, r, er, as, ws, ds);
        n_cmp++; if (w !== 17 || r !== 16) begin
            n_err++; $display("FAIL ack_timeout_len: waits=%0d reqs=%0d expected 17 16", w, r); end
        n_cmp++; if (er !== 0) begin n_err++; $display("FAIL ack_timeout_err: bus_err cycles=%0d expected 0", er); end
        exp_q.push_back(8'hA5);
        drive(16'h0100, 1'b1, 8'h11, 1'b0);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL ack_timeout_di: DI=%h expected %h", DI, e); end
    endtask

    task automatic test_boundary();
        int w, r, er; logic [15:0] as; logic ws; logic [7:0] ds; logic [7:0] e;
        drive(16'h01FF, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (RDY !== 1'b1) begin n_err++; $display("FAIL edge_int_rdy: RDY=%b expected 1", RDY); end
        exp_q.push_back(model[16'h1FF]);
        run_ext(16'h0200, 1'b0, 8'h00, 1, 8'h4B, w, r, er, as, ws, ds);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL edge_int_di: DI=%h expected %h", DI, e); end
        n_cmp++; if (w !== 2 || as !== 16'h0200) begin
            n_err++; $display("FAIL edge_ext: waits=%0d addr=%h expected 2 0200", w, as); end
        exp_q.push_back(8'h4B);
        drive(16'h0042, 1'b0, 8'h00, 1'b0);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL edge_ext_di: DI=%h expected %h", DI, e); end
        exp_q.push_back(model[16'h042]);
        drive(16'h0042, 1'b1, 8'h5A, 1'b0);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL edge_next_di: DI=%h expected %h", DI, e); end
    endtask

    task automatic test_stray_ack();
        logic [7:0] e;
        ext_rdata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            drive(16'h0042, 1'b0, 8'h00, (i < 2));
            if (i > 0) begin
                e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
                n_cmp++; if (DI !== e) begin n_err++; $display("FAIL stray_ack_di: DI=%h expected %h", DI, e); end
            end
            n_cmp++; if (RDY !== 1'b1 || ext_req !== 1'b0) begin
                n_err++; $display("FAIL stray_ack_state: RDY=%b ext_req=%b expected 1 0", RDY, ext_req); end
            exp_q.push_back(model[16'h042]);
        end
        drive(16'h0100, 1'b1, 8'h11, 1'b0);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL stray_ack_last_di: DI=%h expected %h", DI, e); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] a;
        logic [7:0] d, e;
        for (int i = 0; i < 6; i++) begin
            a = 9'(i * 37 + 300);
            d = 8'($urandom_range(0, 255));
            drive({7'b0, a}, 1'b1, d, 1'b0);
            model[a] = d;
        end
        for (int i = 0; i < 7; i++) begin
            a = 9'(i * 37 + 300);
            drive({7'b0, a}, 1'b0, 8'h00, 1'b0);
            if (i > 0) begin
                e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
                n_cmp++; if (DI !== e) begin n_err++; $display("FAIL b2b_di[%0d]: DI=%h expected %h", i - 1, DI, e); end
            end
            if (i < 6) begin
                n_cmp++; if (RDY !== 1'b1) begin n_err++; $display("FAIL b2b_rdy[%0d]: RDY=%b expected 1", i, RDY); end
                exp_q.push_back(model[a]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_req();
        logic [7:0] e;
        drive(16'h9000, 1'b0, 8'h00, 1'b0);
        drive(16'h9000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #2 RST_N = 1'b0;
        #1;
        n_cmp++; if (ext_req !== 1'b0 || RDY !== 1'b0) begin
            n_err++; $display("FAIL midreq_reset: ext_req=%b RDY=%b expected 0 0", ext_req, RDY); end
        @(negedge clk);
        RST_N = 1'b1; AB = 16'h0042; WE = 1'b0; ext_ack = 1'b0;
        #4;
        n_cmp++; if (DI !== 8'h00 || bus_err !== 1'b0) begin
            n_err++; $display("FAIL midreq_post: DI=%h bus_err=%b expected 00 0", DI, bus_err); end
        n_cmp++; if (RDY !== 1'b1 || ext_req !== 1'b0) begin
            n_err++; $display("FAIL midreq_idle: RDY=%b ext_req=%b expected 1 0", RDY, ext_req); end
        exp_q.push_back(model[16'h042]);
        drive(16'h0100, 1'b1, 8'h11, 1'b0);
        e = 8'hxx; if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++; if (DI !== e) begin n_err++; $display("FAIL midreq_read_di: DI=%h expected %h", DI, e); end
    endtask

    initial begin
        test_reset();
        test_int_rw();
        test_ext_read();
        test_ext_write();
        test_timeout();
        test_ack_at_timeout();
        test_boundary();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
